// File: rtl/kyber_stream_pkg.sv
// kyber_stream_pkg: shared types and lane packing for the
// byte-to-lane stream stage of the SHA3/SHAKE absorb path.
package kyber_stream_pkg;

   localparam int LANE_BYTES = 8;
   localparam int MAX_BYTES  = 1024;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } stream_state_t;

   typedef logic [63:0] lane_t;
   typedef logic [8*MAX_BYTES-1:0] flat_buf_t;

   // Bytes past the message are zero in the flat image, so padding is free.
   function automatic lane_t pack_lane(
      input flat_buf_t   buffer,
      input int unsigned wcnt
   );
      lane_t l;
      l = '0;
      for (int j = 0; j < LANE_BYTES; j++) begin
         l[8*j +: 8] = buffer[8*(LANE_BYTES*wcnt + j) +: 8];
      end
      return l;
   endfunction

endpackage

// File: rtl/bytes_to_lane_streamer.sv
// bytes_to_lane_streamer: captures a byte array and streams it out as
// 64-bit little-endian lane words over a valid/ready handshake.
module bytes_to_lane_streamer
   import kyber_stream_pkg::*;
#(
   parameter int BYTE_LENGTH = 128,
   localparam int NUM_WORDS = (BYTE_LENGTH + LANE_BYTES - 1) / LANE_BYTES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  byte_array [BYTE_LENGTH-1:0],
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_word,
   output logic        out_last,
   output logic [3:0]  out_nbytes,
   output logic        done
);

   localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int PEN_INT = (NUM_WORDS > 1) ? NUM_WORDS - 2 : 0;
   localparam logic [WCW-1:0] PEN = WCW'(PEN_INT);
   localparam int LAST_INT = BYTE_LENGTH - LANE_BYTES * (NUM_WORDS - 1);
   localparam logic [3:0] LAST_NB = 4'(LAST_INT);
   localparam logic [3:0] FULL_NB = 4'(LANE_BYTES);
   localparam logic ONE_WORD = (NUM_WORDS == 1);

   stream_state_t  state;
   logic [WCW-1:0] wcnt;
   logic [7:0]     buffer [BYTE_LENGTH];
   flat_buf_t      flat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BYTE_LENGTH; i++) begin
            buffer[i] <= '0;
         end
      end else if (state == IDLE && start) begin
         for (int i = 0; i < BYTE_LENGTH; i++) begin
            buffer[i] <= byte_array[i];
         end
      end
   end

   always_comb begin
      flat = '0;
      for (int i = 0; i < BYTE_LENGTH; i++) begin
         flat[8*i +: 8] = buffer[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wcnt       <= '0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_nbytes <= '0;
         done       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= STREAM;
                  wcnt       <= '0;
                  busy       <= 1'b1;
                  out_valid  <= 1'b1;
                  out_last   <= ONE_WORD;
                  out_nbytes <= ONE_WORD ? LAST_NB : FULL_NB;
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (out_last) begin
                     state      <= DONE;
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     out_nbytes <= '0;
                     done       <= 1'b1;
                  end else begin
                     // Tag the upcoming word from the counter before it moves.
                     wcnt       <= wcnt + 1'b1;
                     out_last   <= (wcnt == PEN);
                     out_nbytes <= (wcnt == PEN) ? LAST_NB : FULL_NB;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign out_word = out_valid ? pack_lane(flat, 32'(wcnt)) : '0;

endmodule
